zap_ldm_writeback_seq: RTL and testbench
========================================

# zap_ldm_writeback_seq

Block-load writeback sequencer sitting directly upstream of the flip-flop register file write port A. Accepts a load-multiple command (16-bit architectural register list plus bank offset), then consumes one 32-bit load-data beat per listed register. For each beat it issues one register-file write in ascending register order. It also exports a 40-bit pending scoreboard so decode can interlock reads of registers still awaiting load data.

## Interface
- NUM_PHYS, 40, physical register-file entries; indices ≥ NUM_PHYS are invalid
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_flush  in  1  abort current command; priority over everything except reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  command accepted when valid & ready
- i_cmd_list  in  16  bit n set = load architectural rn
- i_cmd_bank_offset  in  6  added to index for r8–r14
- i_data_valid  in  1  load-data beat offered
- o_data_ready  out  1  beat accepted when valid & ready
- i_data  in  32  load data
- o_wen  out  1  register-file write enable (drives write port A)
- o_wr_addr  out  6  physical write index
- o_wr_data  out  32  write data
- o_pending  out  40  bit i set = physical register i awaiting write
- o_done  out  1  one-cycle pulse at command completion
- o_err  out  1  sticky: command contained an out-of-range mapping

## Operation
- Mapping: r0–r7 and r15 map to their own index. For rn with n = 8..14, the physical index is (n + i_cmd_bank_offset) mod 64, using a 6-bit wrap. A mapped index ≥ NUM_PHYS is out of range.
- States: IDLE, LOAD.
- IDLE:
  - o_cmd_ready = ~i_flush (combinational); o_data_ready = 0.
  - On accept, latch the list into remaining_q and latch the offset.
  - Non-empty list: go to LOAD.
  - Empty list: stay in IDLE, pulse o_done next cycle, issue no writes.
- LOAD:
  - o_data_ready = ~i_flush; o_cmd_ready = 0.
  - Each accepted beat targets the lowest set bit of remaining_q; that bit is cleared at the next edge.
  - When the bit clears to zero, return to IDLE.
- Out-of-range bits still consume a beat, with o_wen held 0 for that beat. o_err is set at command accept if any listed register maps out of range. o_err clears on the next accepted command or on reset.
- Colliding mappings (two list bits map to the same index): both writes are issued in list order, so the later write wins.
- o_pending next value:
  - On accept: the mapped in-range bits of i_cmd_list.
  - Otherwise: the mapped in-range bits of remaining_q.
  - A collided index therefore stays pending until its final write.
- Flush:
  - Next cycle: state IDLE, remaining_q = 0, o_pending = 0, o_wen = 0.
  - No o_done is produced; o_err keeps its value.
  - A command or beat presented in the flush cycle is not accepted.

## Timing
- Reset values: o_wen 0, o_wr_addr 0, o_wr_data 0, o_pending 0, o_done 0, o_err 0, state IDLE. o_cmd_ready = 1 the cycle after reset (absent flush); o_data_ready = 0.
- Write latency:
  - Beat accepted in cycle t → o_wen/o_wr_addr/o_wr_data valid in cycle t+1 for exactly one cycle.
  - The register file commits at the end of t+1.
- Pending:
  - Set in cycle t+1 after command accept at t, so there is no unprotected cycle.
  - A bit clears in cycle t+2 for a beat accepted at t, i.e. one cycle after its o_wen, once the register file holds the data.
- o_done asserts in the same cycle as the final o_wen.
- The earliest new command is accepted in the cycle after the final beat's acceptance, i.e. the same cycle as the final o_wen. Back-to-back commands are therefore possible with no bubble.
- Throughput: one beat per cycle. i_data_valid gaps insert o_wen=0 cycles with no state change.
- Outputs are registered except o_cmd_ready and o_data_ready.
- Reset mid-LOAD: all state and outputs return to reset values at the next edge; no write or done is produced.

## Test plan
- List 0x0003, offset 0, beats 0xAAAA0000 then 0xBBBB0000 on consecutive cycles:
  - Writes idx0=0xAAAA0000, then idx1=0xBBBB0000 on consecutive cycles.
  - o_done with the second write.
  - o_pending 0x3 → 0x2 → 0x0.
- List 0x4100, offset 16, beats with one idle gap between them:
  - Writes idx24 then idx30, with a bubble cycle between them.
  - o_err = 0.
- List 0x4001, offset 30, two beats:
  - First beat writes idx0.
  - r14 maps to 44: its beat is consumed with o_wen = 0.
  - o_err = 1 (sticky).
  - o_pending never has bit 44 equivalents; it is 0x1 after accept, then 0.
- Empty list 0x0000:
  - o_done pulses one cycle after accept.
  - No writes; o_data_ready stays 0.
- List 0x00F0, flush after second beat:
  - Exactly two writes, idx4 and idx5.
  - Then o_pending = 0 and state IDLE; no o_done.
  - The next command is accepted normally.
- Reset asserted mid-LOAD with beats pending:
  - Every output is at its reset value the next cycle.
  - Any in-flight beat produces no write.

Source files
------------

// File: rtl/zap_ldm_writeback_seq.sv
// Load-multiple writeback sequencer: turns a register-list command plus a
// stream of load-data beats into ascending-order register-file writes, and
// publishes a scoreboard of physical registers still awaiting their data.
module zap_ldm_writeback_seq (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [15:0] i_cmd_list,
    input  logic [5:0]  i_cmd_bank_offset,
    input  logic        i_data_valid,
    output logic        o_data_ready,
    input  logic [31:0] i_data,
    output logic        o_wen,
    output logic [5:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [39:0] o_pending,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned NUM_PHYS = 40;
    localparam int unsigned LIST_W   = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [5:0]  offset_q, offset_d;
    logic        wen_d, done_d, err_d;
    logic [5:0]  addr_d;
    logic [31:0] data_d;
    logic [39:0] pending_d;
    logic [5:0]  beat_idx;
    logic [15:0] remaining_cleared;

    // r8-r14 are banked: shifted by the offset with a 6-bit wrap
    function automatic logic [5:0] map_idx(input logic [3:0] n, input logic [5:0] off);
        logic [5:0] idx;
        idx = {2'b00, n};
        if (n >= 4'd8 && n <= 4'd14) begin
            idx = idx + off;
        end
        return idx;
    endfunction

    function automatic logic in_range(input logic [5:0] idx);
        return 32'(idx) < NUM_PHYS;
    endfunction

    // Scoreboard bits for every in-range mapping of a register list
    function automatic logic [39:0] pend_mask(input logic [15:0] list, input logic [5:0] off);
        logic [39:0] m;
        logic [5:0]  idx;
        m = '0;
        for (int n = 0; n < int'(LIST_W); n++) begin
            idx = map_idx(4'(n), off);
            if (list[n] && in_range(idx)) begin
                m[idx] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic any_out_of_range(input logic [15:0] list, input logic [5:0] off);
        logic bad;
        bad = 1'b0;
        for (int n = 0; n < int'(LIST_W); n++) begin
            if (list[n] && !in_range(map_idx(4'(n), off))) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] list);
        logic [3:0] n;
        n = '0;
        for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
            if (list[i]) begin
                n = 4'(i);
            end
        end
        return n;
    endfunction

    // Next-state, next-output and handshake decode
    always_comb begin
        state_d           = state_q;
        remaining_d       = remaining_q;
        offset_d          = offset_q;
        wen_d             = 1'b0;
        addr_d            = o_wr_addr;
        data_d            = o_wr_data;
        pending_d         = pend_mask(remaining_q, offset_q);
        done_d            = 1'b0;
        err_d             = o_err;
        o_cmd_ready       = 1'b0;
        o_data_ready      = 1'b0;
        beat_idx          = map_idx(lowest_set(remaining_q), offset_q);
        remaining_cleared = remaining_q & (remaining_q - 16'd1);

        case (state_q)
            IDLE: begin
                o_cmd_ready = ~i_flush;
                if (i_cmd_valid && !i_flush) begin
                    remaining_d = i_cmd_list;
                    offset_d    = i_cmd_bank_offset;
                    pending_d   = pend_mask(i_cmd_list, i_cmd_bank_offset);
                    err_d       = any_out_of_range(i_cmd_list, i_cmd_bank_offset);
                    if (i_cmd_list == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                o_data_ready = ~i_flush;
                if (i_data_valid && !i_flush) begin
                    wen_d       = in_range(beat_idx);
                    addr_d      = beat_idx;
                    data_d      = i_data;
                    remaining_d = remaining_cleared;
                    if (remaining_cleared == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush abandons the command but leaves the error flag alone
        if (i_flush) begin
            state_d     = IDLE;
            remaining_d = '0;
            pending_d   = '0;
            wen_d       = 1'b0;
            done_d      = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            offset_q    <= '0;
            o_wen       <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_pending   <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            o_wen       <= wen_d;
            o_wr_addr   <= addr_d;
            o_wr_data   <= data_d;
            o_pending   <= pending_d;
            o_done      <= done_d;
            o_err       <= err_d;
        end
    end

endmodule

// File: tb/tb_zap_ldm_writeback_seq.sv
// Bench for zap_ldm_writeback_seq: directed scenarios plus a long random run,
// all checked against a queue-based reference model of the sequencer.
module tb_zap_ldm_writeback_seq;

    localparam int NUM_PHYS = 40;

    logic        i_clk = 1'b0;
    logic        i_reset, i_flush, i_cmd_valid, i_data_valid;
    logic [15:0] i_cmd_list;
    logic [5:0]  i_cmd_bank_offset;
    logic [31:0] i_data;
    logic        o_cmd_ready, o_data_ready, o_wen, o_done, o_err;
    logic [5:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic [39:0] o_pending;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the registers still owed a beat, in write order
    bit          m_busy = 1'b0;
    int          m_rem[$];
    logic [5:0]  m_off = '0;
    logic        e_wen = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [5:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    logic [39:0] e_pend = '0;

    // Handshake outputs captured just before each rising edge
    logic s_cmd_rdy, s_data_rdy;

    always #5 i_clk = ~i_clk;

    zap_ldm_writeback_seq dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_flush           (i_flush),
        .i_cmd_valid       (i_cmd_valid),
        .o_cmd_ready       (o_cmd_ready),
        .i_cmd_list        (i_cmd_list),
        .i_cmd_bank_offset (i_cmd_bank_offset),
        .i_data_valid      (i_data_valid),
        .o_data_ready      (o_data_ready),
        .i_data            (i_data),
        .o_wen             (o_wen),
        .o_wr_addr         (o_wr_addr),
        .o_wr_data         (o_wr_data),
        .o_pending         (o_pending),
        .o_done            (o_done),
        .o_err             (o_err)
    );

    function automatic int map_reg(input int n, input logic [5:0] off);
        if (n >= 8 && n <= 14) return (n + int'(off)) % 64;
        return n;
    endfunction

    function automatic logic [39:0] pend_of_rem();
        logic [39:0] p;
        int a;
        p = '0;
        foreach (m_rem[i]) begin
            a = map_reg(m_rem[i], m_off);
            if (a < NUM_PHYS) p[a] = 1'b1;
        end
        return p;
    endfunction

    // Advance the model across one rising edge
    task automatic model_step(input logic cv, input logic [15:0] list, input logic [5:0] off,
                              input logic dv, input logic [31:0] data, input logic fl,
                              input logic rst);
        logic [39:0] pend_before;
        int n, a;
        pend_before = pend_of_rem();
        e_wen  = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_rem.delete(); m_off = '0;
            e_addr = '0; e_data = '0; e_pend = '0; e_err = 1'b0;
        end else if (fl) begin
            m_busy = 1'b0; m_rem.delete(); e_pend = '0;
        end else if (!m_busy && cv) begin
            m_off = off; m_rem.delete(); e_err = 1'b0;
            for (int r = 0; r < 16; r++) begin
                if (list[r]) begin
                    m_rem.push_back(r);
                    if (map_reg(r, off) >= NUM_PHYS) e_err = 1'b1;
                end
            end
            e_pend = pend_of_rem();
            if (m_rem.size() == 0) e_done = 1'b1;
            else m_busy = 1'b1;
        end else if (m_busy && dv) begin
            n = m_rem.pop_front();
            a = map_reg(n, m_off);
            e_wen  = (a < NUM_PHYS);
            e_addr = 6'(a);
            e_data = data;
            e_pend = pend_before;
            if (m_rem.size() == 0) begin
                m_busy = 1'b0;
                e_done = 1'b1;
            end
        end else begin
            e_pend = pend_before;
        end
    endtask

    // One clock cycle: drive at mid-cycle, capture ready, cross the edge, return mid-cycle
    task automatic tick(input logic cv, input logic [15:0] list, input logic [5:0] off,
                        input logic dv, input logic [31:0] data, input logic fl, input logic rst);
        i_cmd_valid = cv; i_cmd_list = list; i_cmd_bank_offset = off;
        i_data_valid = dv; i_data = data; i_flush = fl; i_reset = rst;
        #1;
        s_cmd_rdy  = o_cmd_ready;
        s_data_rdy = o_data_ready;
        @(posedge i_clk);
        model_step(cv, list, off, dv, data, fl, rst);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 16'h0, 6'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 16'h0, 6'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_cmp++;
        if (o_wen !== 1'b0 || o_wr_addr !== 6'd0 || o_wr_data !== 32'h0 || o_pending !== 40'h0 ||
            o_done !== 1'b0 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got wen=%b addr=%0d data=%h pend=%h done=%b err=%b want all zero",
                     o_wen, o_wr_addr, o_wr_data, o_pending, o_done, o_err);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (s_cmd_rdy !== 1'b1 || s_data_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready got cmd_ready=%b data_ready=%b want 1/0", s_cmd_rdy, s_data_rdy);
        end
    endtask

    task automatic test_basic();
        tick(1'b1, 16'h0003, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (o_pending !== 40'h3 || o_wen !== 1'b0) begin
            n_bad++; $display("FAIL basic_accept got pend=%h wen=%b want 3/0", o_pending, o_wen);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'hAAAA0000, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd0 || o_wr_data !== 32'hAAAA0000 || o_pending !== 40'h3 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL basic_w0 got wen=%b addr=%0d data=%h pend=%h done=%b want 1/0/aaaa0000/3/0",
                              o_wen, o_wr_addr, o_wr_data, o_pending, o_done);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'hBBBB0000, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd1 || o_wr_data !== 32'hBBBB0000 || o_pending !== 40'h2 || o_done !== 1'b1) begin
            n_bad++; $display("FAIL basic_w1 got wen=%b addr=%0d data=%h pend=%h done=%b want 1/1/bbbb0000/2/1",
                              o_wen, o_wr_addr, o_wr_data, o_pending, o_done);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b0 || o_pending !== 40'h0 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL basic_after got wen=%b pend=%h done=%b want 0/0/0", o_wen, o_pending, o_done);
        end
    endtask

    task automatic test_gap();
        logic [31:0] d1, d2;
        d1 = $urandom; d2 = $urandom;
        tick(1'b1, 16'h4100, 6'd16, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (o_pending !== 40'h0041000000 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL gap_accept got pend=%h err=%b want 0041000000/0", o_pending, o_err);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, d1, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd24 || o_wr_data !== d1 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL gap_w24 got wen=%b addr=%0d data=%h done=%b want 1/24/%h/0",
                              o_wen, o_wr_addr, o_wr_data, o_done, d1);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b0 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL gap_bubble got wen=%b done=%b want 0/0", o_wen, o_done);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, d2, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd30 || o_wr_data !== d2 || o_done !== 1'b1 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL gap_w30 got wen=%b addr=%0d data=%h done=%b err=%b want 1/30/%h/1/0",
                              o_wen, o_wr_addr, o_wr_data, o_done, o_err, d2);
        end
    endtask

    task automatic test_out_of_range();
        tick(1'b1, 16'h4001, 6'd30, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (o_pending !== 40'h1 || o_err !== 1'b1) begin
            n_bad++; $display("FAIL oor_accept got pend=%h err=%b want 1/1", o_pending, o_err);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h11112222, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd0 || o_wr_data !== 32'h11112222 || o_pending !== 40'h1) begin
            n_bad++; $display("FAIL oor_w0 got wen=%b addr=%0d data=%h pend=%h want 1/0/11112222/1",
                              o_wen, o_wr_addr, o_wr_data, o_pending);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h33334444, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b0 || o_done !== 1'b1 || o_pending !== 40'h0) begin
            n_bad++; $display("FAIL oor_consumed got wen=%b done=%b pend=%h want 0/1/0", o_wen, o_done, o_pending);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (o_err !== 1'b1 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL oor_sticky got err=%b done=%b want 1/0", o_err, o_done);
        end
    endtask

    task automatic test_empty();
        tick(1'b1, 16'h0000, 6'($urandom), 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (o_done !== 1'b1 || o_wen !== 1'b0 || o_err !== 1'b0 || o_pending !== 40'h0) begin
            n_bad++; $display("FAIL empty_done got done=%b wen=%b err=%b pend=%h want 1/0/0/0",
                              o_done, o_wen, o_err, o_pending);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h5555AAAA, 1'b0, 1'b0);
        n_cmp++;
        if (s_data_rdy !== 1'b0 || o_done !== 1'b0 || o_wen !== 1'b0) begin
            n_bad++; $display("FAIL empty_after got data_ready=%b done=%b wen=%b want 0/0/0",
                              s_data_rdy, o_done, o_wen);
        end
    endtask

    task automatic test_flush();
        tick(1'b1, 16'h00F0, 6'($urandom), 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (o_pending !== 40'hF0) begin
            n_bad++; $display("FAIL flush_accept got pend=%h want f0", o_pending);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h44440000, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd4 || o_wr_data !== 32'h44440000) begin
            n_bad++; $display("FAIL flush_w4 got wen=%b addr=%0d data=%h want 1/4/44440000", o_wen, o_wr_addr, o_wr_data);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h55550000, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd5 || o_wr_data !== 32'h55550000) begin
            n_bad++; $display("FAIL flush_w5 got wen=%b addr=%0d data=%h want 1/5/55550000", o_wen, o_wr_addr, o_wr_data);
        end
        tick(1'b1, 16'h0001, 6'd0, 1'b1, 32'h66660000, 1'b1, 1'b0);
        n_cmp++;
        if (s_data_rdy !== 1'b0 || s_cmd_rdy !== 1'b0 || o_wen !== 1'b0 || o_pending !== 40'h0 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL flush_cycle got data_ready=%b cmd_ready=%b wen=%b pend=%h done=%b want 0/0/0/0/0",
                              s_data_rdy, s_cmd_rdy, o_wen, o_pending, o_done);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h77770000, 1'b0, 1'b0);
        n_cmp++;
        if (s_data_rdy !== 1'b0 || s_cmd_rdy !== 1'b1 || o_wen !== 1'b0 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL flush_idle got data_ready=%b cmd_ready=%b wen=%b done=%b want 0/1/0/0",
                              s_data_rdy, s_cmd_rdy, o_wen, o_done);
        end
        tick(1'b1, 16'h0001, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h88880000, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd0 || o_wr_data !== 32'h88880000 || o_done !== 1'b1) begin
            n_bad++; $display("FAIL flush_next got wen=%b addr=%0d data=%h done=%b want 1/0/88880000/1",
                              o_wen, o_wr_addr, o_wr_data, o_done);
        end
    endtask

    task automatic test_reset_mid_load();
        tick(1'b1, 16'hFFFF, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h01010101, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h02020202, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h03030303, 1'b0, 1'b1);
        n_cmp++;
        if (o_wen !== 1'b0 || o_wr_addr !== 6'd0 || o_wr_data !== 32'h0 || o_pending !== 40'h0 ||
            o_done !== 1'b0 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_outputs got wen=%b addr=%0d data=%h pend=%h done=%b err=%b want all zero",
                              o_wen, o_wr_addr, o_wr_data, o_pending, o_done, o_err);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'h04040404, 1'b0, 1'b0);
        n_cmp++;
        if (s_data_rdy !== 1'b0 || s_cmd_rdy !== 1'b1 || o_wen !== 1'b0 || o_done !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_after got data_ready=%b cmd_ready=%b wen=%b done=%b want 0/1/0/0",
                              s_data_rdy, s_cmd_rdy, o_wen, o_done);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 16'h0003, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'hC0DE0001, 1'b0, 1'b0);
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'hC0DE0002, 1'b0, 1'b0);
        tick(1'b1, 16'h0300, 6'd5, 1'b1, 32'hDEAD0000, 1'b0, 1'b0);
        n_cmp++;
        if (s_cmd_rdy !== 1'b1 || o_pending !== 40'h6000 || o_wen !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept got cmd_ready=%b pend=%h wen=%b want 1/6000/0", s_cmd_rdy, o_pending, o_wen);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'hC0DE0003, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd13 || o_wr_data !== 32'hC0DE0003) begin
            n_bad++; $display("FAIL b2b_w13 got wen=%b addr=%0d data=%h want 1/13/c0de0003", o_wen, o_wr_addr, o_wr_data);
        end
        tick(1'b0, 16'h0, 6'd0, 1'b1, 32'hC0DE0004, 1'b0, 1'b0);
        n_cmp++;
        if (o_wen !== 1'b1 || o_wr_addr !== 6'd14 || o_done !== 1'b1 || o_pending !== 40'h4000) begin
            n_bad++; $display("FAIL b2b_w14 got wen=%b addr=%0d done=%b pend=%h want 1/14/1/4000",
                              o_wen, o_wr_addr, o_done, o_pending);
        end
    endtask

    task automatic test_random();
        logic cv, dv, fl, rst, x_crdy, x_drdy;
        logic [15:0] list;
        logic [5:0]  off;
        int sel;
        for (int c = 0; c < 3000; c++) begin
            cv  = ($urandom_range(0, 9) < 4);
            dv  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0) list = 16'h0;
            else if (sel < 5) list = 16'($urandom) & 16'($urandom);
            else list = 16'($urandom) & 16'($urandom) & 16'($urandom);
            off = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 16)) : 6'($urandom);
            x_crdy = !m_busy && !fl;
            x_drdy = m_busy && !fl;
            tick(cv, list, off, dv, 32'($urandom), fl, rst);
            n_cmp++;
            if (s_cmd_rdy !== x_crdy || s_data_rdy !== x_drdy) begin
                n_bad++; $display("FAIL rnd_ready c=%0d got %b/%b want %b/%b", c, s_cmd_rdy, s_data_rdy, x_crdy, x_drdy);
            end
            n_cmp++;
            if (o_wen !== e_wen || (e_wen && (o_wr_addr !== e_addr || o_wr_data !== e_data))) begin
                n_bad++; $display("FAIL rnd_write c=%0d got wen=%b addr=%0d data=%h want wen=%b addr=%0d data=%h",
                                  c, o_wen, o_wr_addr, o_wr_data, e_wen, e_addr, e_data);
            end
            n_cmp++;
            if (o_pending !== e_pend) begin
                n_bad++; $display("FAIL rnd_pending c=%0d got %h want %h", c, o_pending, e_pend);
            end
            n_cmp++;
            if (o_done !== e_done || o_err !== e_err) begin
                n_bad++; $display("FAIL rnd_done_err c=%0d got done=%b err=%b want done=%b err=%b",
                                  c, o_done, o_err, e_done, e_err);
            end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_flush = 1'b0; i_cmd_valid = 1'b0; i_data_valid = 1'b0;
        i_cmd_list = '0; i_cmd_bank_offset = '0; i_data = '0;
        @(negedge i_clk);
        test_reset();
        test_basic();
        test_gap();
        test_out_of_range();
        test_empty();
        test_flush();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
